// File: rtl/midi_note_stack_if.sv
// Message/voice bus between the MIDI byte decoder and the note stack.
//   master : the message producer (decoder side), drives the 3-byte message and
//            its ready level, observes the voice outputs.
//   slave  : the note stack, consumes messages and drives the voice outputs.
//   midi_status/midi_data1/midi_data2 : last complete message
//   midi_msg_rdy : level, high for many clocks once per message
//   note/velocity/gate/note_trig/busy : monophonic voice control
interface midi_note_stack_if;
  logic [7:0] midi_status;
  logic [7:0] midi_data1;
  logic [7:0] midi_data2;
  logic       midi_msg_rdy;
  logic [6:0] note;
  logic [6:0] velocity;
  logic       gate;
  logic       note_trig;
  logic       busy;

  modport master (
    output midi_status, midi_data1, midi_data2, midi_msg_rdy,
    input  note, velocity, gate, note_trig, busy
  );

  modport slave (
    input  midi_status, midi_data1, midi_data2, midi_msg_rdy,
    output note, velocity, gate, note_trig, busy
  );
endinterface

// File: rtl/midi_note_stack.sv
// Last-note-priority monophonic note stack.
// Turns decoded MIDI messages into note/velocity/gate/retrigger for one voice.
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : midi_note_stack_if.slave (message in, voice control out)
// Parameters:
//   DEPTH   : held notes remembered (2..16); oldest dropped on overflow
//   CHANNEL : accepted MIDI channel (0..15)
//   OMNI    : 1 = accept every channel
module midi_note_stack #(
  parameter int DEPTH   = 8,
  parameter int CHANNEL = 0,
  parameter bit OMNI    = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  midi_note_stack_if.slave   bus
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_SHIFT, S_PUSH, S_DONE} state_t;
  typedef enum logic [1:0] {CMD_NONE, CMD_ON, CMD_OFF, CMD_ALL_OFF} cmd_t;

  function automatic cmd_t decode(input logic [7:0] st, input logic [7:0] d1,
                                  input logic [7:0] d2);
    cmd_t c;
    c = CMD_NONE;
    if (st[7] && (OMNI || st[3:0] == 4'(CHANNEL))) begin
      case (st[7:4])
        4'h9:    c = (d2[6:0] != 7'd0) ? CMD_ON : CMD_OFF;
        4'h8:    c = CMD_OFF;
        4'hB:    if (d1 == 8'd123) c = CMD_ALL_OFF;
        default: c = CMD_NONE;
      endcase
    end
    return c;
  endfunction

  state_t        state;
  logic [6:0]    stk [DEPTH];
  logic [CW-1:0] count;
  logic [IW-1:0] idx;
  logic [IW-1:0] top_idx;
  logic          op_on;
  logic [6:0]    op_note;
  logic [6:0]    op_vel;

  logic          rdy_q, rdy_qq;
  logic          msg_edge;
  logic          pend;
  logic [7:0]    pend_status, pend_d1, pend_d2;

  logic [6:0]    note_q, vel_q;
  logic          gate_q, trig_q, busy_q;

  // Message presented to IDLE: a parked message has priority over a fresh edge.
  logic          src_valid;
  logic [7:0]    src_status, src_d1, src_d2;
  cmd_t          src_cmd;

  assign msg_edge = rdy_q & ~rdy_qq;
  assign top_idx  = IW'(count - CW'(1));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    src_valid  = pend | msg_edge;
    src_status = pend ? pend_status : bus.midi_status;
    src_d1     = pend ? pend_d1     : bus.midi_data1;
    src_d2     = pend ? pend_d2     : bus.midi_data2;
    src_cmd    = CMD_NONE;
    if (src_valid) src_cmd = decode(src_status, src_d1, src_d2);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every read
  // in this block sees the value from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q       <= 1'b0;
      rdy_qq      <= 1'b0;
      pend        <= 1'b0;
      pend_status <= '0;
      pend_d1     <= '0;
      pend_d2     <= '0;
      state       <= S_IDLE;
      count       <= '0;
      idx         <= '0;
      op_on       <= 1'b0;
      op_note     <= '0;
      op_vel      <= '0;
      note_q      <= '0;
      vel_q       <= '0;
      gate_q      <= 1'b0;
      trig_q      <= 1'b0;
      busy_q      <= 1'b0;
      // NOTE: stk is deliberately not reset; count=0 means no entry is ever read.
    end else begin
      rdy_q  <= bus.midi_msg_rdy;
      rdy_qq <= rdy_q;
      trig_q <= 1'b0;

      // One-deep parking slot for a message arriving while an op is running.
      // In IDLE a parked message is consumed; a coincident new edge takes its place.
      if (state == S_IDLE) begin
        if (pend) pend <= msg_edge;
        if (pend && msg_edge) begin
          pend_status <= bus.midi_status;
          pend_d1     <= bus.midi_data1;
          pend_d2     <= bus.midi_data2;
        end
      end else if (msg_edge && !pend) begin
        pend        <= 1'b1;
        pend_status <= bus.midi_status;
        pend_d1     <= bus.midi_data1;
        pend_d2     <= bus.midi_data2;
      end

      case (state)
        S_IDLE: begin
          if (src_cmd != CMD_NONE) begin
            busy_q  <= 1'b1;
            op_on   <= (src_cmd == CMD_ON);
            op_note <= src_d1[6:0];
            op_vel  <= src_d2[6:0];
            idx     <= '0;
            case (src_cmd)
              CMD_ALL_OFF: begin
                count <= '0;
                state <= S_DONE;
              end
              CMD_ON:  state <= (count == '0) ? S_PUSH : S_SEARCH;
              default: state <= (count == '0) ? S_DONE : S_SEARCH;
            endcase
          end
        end

        S_SEARCH: begin
          if (stk[idx] == op_note)  state <= S_SHIFT;
          else if (idx == top_idx)  state <= op_on ? S_PUSH : S_DONE;
          else                      idx   <= idx + IW'(1);
        end

        // Close the gap left by the hit entry, one slot per clock.
        S_SHIFT: begin
          if (idx == top_idx) begin
            count <= count - CW'(1);
            state <= op_on ? S_PUSH : S_DONE;
          end else begin
            stk[idx] <= stk[idx + IW'(1)];
            idx      <= idx + IW'(1);
          end
        end

        // Full stack: drop the oldest and place the new note on top in one clock.
        S_PUSH: begin
          if (count == CW'(DEPTH)) begin
            for (int k = 0; k < DEPTH - 1; k++) stk[k] <= stk[k + 1];
            stk[DEPTH-1] <= op_note;
          end else begin
            stk[IW'(count)] <= op_note;
            count           <= count + CW'(1);
          end
          state <= S_DONE;
        end

        // The only place the voice outputs change.
        S_DONE: begin
          busy_q <= 1'b0;
          gate_q <= (count != '0);
          if (count != '0) note_q <= stk[top_idx];
          if (op_on) begin
            trig_q <= 1'b1;
            vel_q  <= op_vel;
          end
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.note      = note_q;
  assign bus.velocity  = vel_q;
  assign bus.gate      = gate_q;
  assign bus.note_trig = trig_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_midi_note_stack.sv
// Directed bench for midi_note_stack: one DUT on channel 0 (DEPTH 8), one OMNI DUT.
module tb_midi_note_stack;

  localparam int LIMIT   = 60;
  localparam int MAX_LAT = 2 * 8 + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  midi_note_stack_if m0 ();
  midi_note_stack_if m1 ();

  midi_note_stack #(.DEPTH(8), .CHANNEL(0), .OMNI(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (m0)
  );

  midi_note_stack #(.DEPTH(8), .CHANNEL(0), .OMNI(1'b1)) dut_omni (
    .clk (clk),
    .rst (rst),
    .bus (m1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int trig0 = 0;
  int trig1 = 0;
  int last_trig_cyc = 0;
  int start_cyc = 0;
  bit busy_seen = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (m0.note_trig === 1'b1) begin
      trig0++;
      last_trig_cyc = cyc;
    end
    if (m1.note_trig === 1'b1) trig1++;
    if (m0.busy === 1'b1) busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input bit omni);
    int n = 0;
    while (((omni ? m1.busy : m0.busy) !== 1'b0) && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n == LIMIT) check("busy_timeout", n, 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic send(input bit omni, input logic [7:0] st, input logic [7:0] d1,
                      input logic [7:0] d2, input int hold);
    busy_seen = 1'b0;
    start_cyc = cyc;
    if (omni) begin
      m1.midi_status = st; m1.midi_data1 = d1; m1.midi_data2 = d2; m1.midi_msg_rdy = 1'b1;
    end else begin
      m0.midi_status = st; m0.midi_data1 = d1; m0.midi_data2 = d2; m0.midi_msg_rdy = 1'b1;
    end
    repeat (hold) @(negedge clk);
    if (omni) m1.midi_msg_rdy = 1'b0;
    else      m0.midi_msg_rdy = 1'b0;
    wait_idle(omni);
  endtask

  task automatic on(input int n, input int v);
    send(1'b0, 8'h90, 8'(n), 8'(v), 4);
  endtask

  task automatic off(input int n);
    send(1'b0, 8'h80, 8'(n), 8'h00, 4);
  endtask

  int t;

  initial begin
    m0.midi_status = '0; m0.midi_data1 = '0; m0.midi_data2 = '0; m0.midi_msg_rdy = 1'b0;
    m1.midi_status = '0; m1.midi_data1 = '0; m1.midi_data2 = '0; m1.midi_msg_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_note", m0.note, 0);
    check("rst_vel", m0.velocity, 0);
    check("rst_gate", m0.gate, 0);
    check("rst_trig", m0.note_trig, 0);
    check("rst_busy", m0.busy, 0);

    // 1: single note-on
    t = trig0;
    on(60, 100);
    check("t1_note", m0.note, 60);
    check("t1_vel", m0.velocity, 100);
    check("t1_gate", m0.gate, 1);
    check("t1_trig", trig0 - t, 1);
    check("t1_latency_ok", (last_trig_cyc - start_cyc) <= MAX_LAT, 1);

    // 2: last-note priority and release order
    on(64, 80);
    on(67, 90);
    check("t2_note67", m0.note, 67);
    t = trig0;
    off(67);
    check("t2_note64", m0.note, 64);
    check("t2_gate", m0.gate, 1);
    check("t2_notrig", trig0 - t, 0);
    check("t2_vel_kept", m0.velocity, 90);
    off(64);
    check("t2_note60", m0.note, 60);
    off(60);
    check("t2_gate0", m0.gate, 0);
    check("t2_hold60", m0.note, 60);

    // 3: overflow drops the oldest (60)
    for (int i = 0; i < 9; i++) on(60 + i, 50 + i);
    check("t3_note68", m0.note, 68);
    check("t3_vel58", m0.velocity, 58);
    off(68);
    check("t3_note67", m0.note, 67);
    for (int i = 67; i >= 61; i--) off(i);
    check("t3_gate0", m0.gate, 0);
    check("t3_hold61", m0.note, 61);

    // 4: channel filter, then OMNI
    t = trig0;
    send(1'b0, 8'h91, 8'd60, 8'd100, 4);
    check("t4_nobusy", busy_seen, 0);
    check("t4_gate", m0.gate, 0);
    check("t4_note", m0.note, 61);
    check("t4_notrig", trig0 - t, 0);
    t = trig1;
    send(1'b1, 8'h91, 8'd60, 8'd100, 4);
    check("t4_omni_note", m1.note, 60);
    check("t4_omni_gate", m1.gate, 1);
    check("t4_omni_vel", m1.velocity, 100);
    check("t4_omni_trig", trig1 - t, 1);

    // 5: vel-0 note-on, all-notes-off, re-held note moved to top
    on(60, 100);
    t = trig0;
    send(1'b0, 8'h90, 8'd60, 8'd0, 4);
    check("t5_vel0_gate", m0.gate, 0);
    check("t5_vel0_notrig", trig0 - t, 0);
    on(60, 100);
    on(64, 100);
    on(67, 100);
    send(1'b0, 8'hB0, 8'h7B, 8'h00, 4);
    check("t5_alloff_gate", m0.gate, 0);
    check("t5_alloff_hold", m0.note, 67);
    on(70, 33);
    off(70);
    check("t5_count_cleared", m0.gate, 0);
    on(60, 100);
    on(64, 100);
    t = trig0;
    on(60, 20);
    check("t5_retop_note", m0.note, 60);
    check("t5_retop_vel", m0.velocity, 20);
    check("t5_retop_trig", trig0 - t, 1);
    off(60);
    check("t5_dup_removed", m0.note, 64);
    off(64);
    check("t5_empty", m0.gate, 0);

    // 6: long ready level fires once; reset during SHIFT
    t = trig0;
    send(1'b0, 8'h90, 8'd72, 8'd64, 1000);
    check("t6_one_op", trig0 - t, 1);
    check("t6_note72", m0.note, 72);
    off(72);
    for (int i = 0; i < 8; i++) on(60 + i, 100);
    m0.midi_status = 8'h80; m0.midi_data1 = 8'd60; m0.midi_data2 = 8'd0;
    m0.midi_msg_rdy = 1'b1;
    repeat (5) @(negedge clk);
    check("t6_busy_before_rst", m0.busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_note", m0.note, 0);
    check("t6_rst_vel", m0.velocity, 0);
    check("t6_rst_gate", m0.gate, 0);
    check("t6_rst_busy", m0.busy, 0);
    check("t6_rst_trig", m0.note_trig, 0);
    repeat (4) @(negedge clk);
    m0.midi_msg_rdy = 1'b0;
    wait_idle(1'b0);
    on(65, 100);
    check("t6_post_note", m0.note, 65);
    off(65);
    check("t6_stack_cleared", m0.gate, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: got=%0d expected=%0d", cyc, 0);
    $fatal(1);
  end

endmodule
